cdda_i2s_tx: RTL and testbench

CDDA_I2S_TX -- requirements
Module: cdda_i2s_tx

---
 rtl/cdda_pkg.sv | 25 ++
 rtl/cdda_bck_gen.sv | 45 ++++
 rtl/cdda_i2s_tx.sv | 121 ++++++++++++
 tb/tb_cdda_i2s_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cdda_pkg.sv
// Shared CDDA audio definitions: frame geometry, stereo pair type and the
// I2S slot-to-bit mapping used by the serializer.
package cdda_pkg;

  localparam int SLOTS_PER_FRAME = 64;
  localparam int PCM_WIDTH       = 16;

  typedef struct packed {
    logic signed [PCM_WIDTH-1:0] l;
    logic signed [PCM_WIDTH-1:0] r;
  } cdda_pair_t;

  // I2S: one-slot delay after the lrck edge, MSB first, zero padding after LSB.
  function automatic logic slot_bit(input cdda_pair_t w, input logic [5:0] slot);
    logic [PCM_WIDTH-1:0] word;
    logic [4:0]           p;
    logic [3:0]           idx;
    word = slot[5] ? w.r : w.l;
    p    = slot[4:0];
    idx  = 4'(5'(PCM_WIDTH) - p);
    if (p >= 5'd1 && p <= 5'(PCM_WIDTH)) return word[idx];
    return 1'b0;
  endfunction

endpackage

// File: rtl/cdda_bck_gen.sv
// I2S bit-clock generator: HALF-cycle divider toggling bck, with a one-cycle
// strobe marking the clk edge on which bck falls.
module cdda_bck_gen #(
  parameter int HALF = 14
) (
  input  logic clk,
  input  logic reset_,
  input  logic enable,
  output logic bck,
  output logic bck_fall
);

  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bck_q, bck_d;
  logic             wrap;

  assign wrap     = enable && (div_cnt_q == DIV_W'(HALF - 1));
  assign bck_fall = wrap && bck_q;
  assign bck      = bck_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    bck_d     = bck_q;
    if (!enable) begin
      div_cnt_d = '0;
      bck_d     = 1'b0;
    end else begin
      div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
      if (wrap) bck_d = ~bck_q;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
    end
  end

endmodule

// File: rtl/cdda_i2s_tx.sv
// CDDA stereo I2S transmitter: fetches one PCM pair per 64-slot frame and
// serializes it. Underrun counter present only with CDDA_I2S_UNDERRUN_CNT_EN.
module cdda_i2s_tx
  import cdda_pkg::*;
#(
  parameter int CLK_FREQUENCY = 79027200,
  parameter int SAMPLE_RATE   = 44100
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 enable,
  input  logic [PCM_WIDTH-1:0] sample_l,
  input  logic [PCM_WIDTH-1:0] sample_r,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 bck,
  output logic                 lrck,
  output logic                 sd,
  output logic                 underrun,
  output logic [15:0]          underrun_cnt
);

  localparam int HALF = CLK_FREQUENCY / (SAMPLE_RATE * 2 * SLOTS_PER_FRAME);

  generate
    if (HALF == 0 || HALF * SAMPLE_RATE * 2 * SLOTS_PER_FRAME != CLK_FREQUENCY) begin : g_bad_rate
      $error("cdda_i2s_tx: CLK_FREQUENCY must be a non-zero multiple of SAMPLE_RATE*128");
    end
  endgenerate

  logic bck_fall;

  cdda_bck_gen #(.HALF(HALF)) u_bck_gen (
    .clk      (clk),
    .reset_   (reset_),
    .enable   (enable),
    .bck      (bck),
    .bck_fall (bck_fall)
  );

  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       first_q, first_d;
  logic       lrck_q, lrck_d;
  logic       sd_q, sd_d;
  logic       ready_q, ready_d;
  logic       urun_q, urun_d;
  cdda_pair_t words_q, words_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    first_d   = first_q;
    lrck_d    = lrck_q;
    sd_d      = sd_q;
    ready_d   = 1'b0;
    urun_d    = 1'b0;
    words_d   = words_q;
    if (!enable) begin
      bit_cnt_d = '0;
      first_d   = 1'b1;
      lrck_d    = 1'b0;
      sd_d      = 1'b0;
    end else if (bck_fall) begin
      // The first falling edge after start enters slot 0 rather than advancing.
      bit_cnt_d = first_q ? 6'd0 : bit_cnt_q + 6'd1;
      first_d   = 1'b0;
      if (bit_cnt_d == 6'd0) begin
        if (sample_valid) begin
          words_d.l = sample_l;
          words_d.r = sample_r;
          ready_d   = 1'b1;
        end else begin
          words_d = '0;
          urun_d  = 1'b1;
        end
      end
      lrck_d = bit_cnt_d[5];
      sd_d   = slot_bit(words_d, bit_cnt_d);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      bit_cnt_q <= '0;
      first_q   <= 1'b1;
      lrck_q    <= 1'b0;
      sd_q      <= 1'b0;
      ready_q   <= 1'b0;
      urun_q    <= 1'b0;
      words_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      first_q   <= first_d;
      lrck_q    <= lrck_d;
      sd_q      <= sd_d;
      ready_q   <= ready_d;
      urun_q    <= urun_d;
      words_q   <= words_d;
    end
  end

  assign lrck         = lrck_q;
  assign sd           = sd_q;
  assign sample_ready = ready_q;
  assign underrun     = urun_q;

`ifdef CDDA_I2S_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      urun_cnt_q <= '0;
    else if (urun_d && urun_cnt_q != 16'hFFFF)
      urun_cnt_q <= urun_cnt_q + 16'd1;
  end

  assign underrun_cnt = urun_cnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_cdda_i2s_tx.sv
// Bench for cdda_i2s_tx: offered pairs go into a scoreboard queue, the serial
// stream is decoded per bck fall and compared against popped pairs.
module tb_cdda_i2s_tx;
  import cdda_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample_l = '0, sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bck, lrck, sd, underrun;
  logic [15:0] underrun_cnt;

  always #5 clk = ~clk;

  cdda_i2s_tx dut (
    .clk(clk), .reset_(reset_), .enable(enable),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bck(bck), .lrck(lrck), .sd(sd),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  cdda_pair_t tbl [5] = '{'{16'hA5C3, 16'h0001}, '{16'hA5C3, 16'h0001},
                          '{16'h8000, 16'h7FFF}, '{16'hFFFF, 16'hFFFF},
                          '{16'h1234, 16'h8001}};
  cdda_pair_t exp_q [$];
  cdda_pair_t cur = '0;
  int   tbl_i = 0;
  bit   presented = 0;
  int   cyc = 0, last_fall = 0;
  bit   have_fall = 0, m_first = 1;
  logic [5:0] m_slot = '0;
  int   exp_urun = 0;
  int   stray_rdy = 0, stray_ur = 0, stray_lr = 0, stray_sd = 0;
  logic prev_bck = 0, prev_lrck = 0, prev_sd = 0;

  // Monitor plus feeder; inputs it drives change only on negedge.
  always @(negedge clk) begin
    bit run, fall, fetch;
    logic [4:0]  p;
    logic [15:0] w;
    logic        e;
    cyc++;
    run   = enable && reset_;
    fall  = run && prev_bck && !bck;
    fetch = 0;
    if (!run) begin m_first = 1; have_fall = 0; end
    if (!reset_) exp_urun = 0;
    if (run && !fall) begin
      if (lrck !== prev_lrck) stray_lr++;
      if (sd !== prev_sd) stray_sd++;
    end
    if (fall) begin
      if (have_fall) chk("bck_period", cyc - last_fall, 28);
      have_fall = 1; last_fall = cyc;
      m_slot  = m_first ? 6'd0 : m_slot + 6'd1;
      m_first = 0;
      chk("lrck", lrck, m_slot[5]);
      if (m_slot == 6'd0) begin
        fetch = 1;
        if (sample_valid) begin
          chk("ready", sample_ready, 1);
          chk("underrun", underrun, 0);
          if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
            cur = '0;
          end else cur = exp_q.pop_front();
        end else begin
          chk("ready", sample_ready, 0);
          chk("underrun", underrun, 1);
          exp_urun++;
          cur = '0;
        end
      end
      p = m_slot[4:0];
      w = m_slot[5] ? cur.r : cur.l;
      e = (p >= 5'd1 && p <= 5'd16) ? w[16 - p] : 1'b0;
      chk("sd", sd, e);
    end
    if (sample_ready && !fetch) stray_rdy++;
    if (underrun && !fetch) stray_ur++;
    if (fetch && sample_valid) begin
      tbl_i = (tbl_i + 1) % 5;
      presented = 0;
    end
    if (!presented) begin
      sample_l = tbl[tbl_i].l;
      sample_r = tbl[tbl_i].r;
      exp_q.push_back(tbl[tbl_i]);
      presented = 1;
    end
    prev_bck = bck; prev_lrck = lrck; prev_sd = sd;
  end

  task automatic measure_first();
    int n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); n++;
      if (sample_ready) break;
    end
    chk("first_fetch", n, 28);
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (sample_ready) ok = 1;
    end
    if (!ok) chk("wait_ready", 0, 1);
  endtask

  task automatic wait_slot(input logic [5:0] s);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk); #1;
      if (enable && reset_ && !m_first && m_slot == s) ok = 1;
    end
    if (!ok) chk("wait_slot", 0, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_bck"}, bck, 0);
    chk({tag, "_lrck"}, lrck, 0);
    chk({tag, "_sd"}, sd, 0);
    chk({tag, "_ready"}, sample_ready, 0);
  endtask

  function automatic int exp_cnt();
`ifdef CDDA_I2S_UNDERRUN_CNT_EN
    return exp_urun;
`else
    return 0;
`endif
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("rst");
    chk("rst_urun", underrun, 0);
    chk("rst_cnt", underrun_cnt, 0);
    #1 reset_ = 1'b1;
    repeat (2) @(negedge clk);
    #2 enable = 1'b1; sample_valid = 1'b1;
    measure_first();
    repeat (3) wait_ready();
    #2 sample_valid = 1'b0;
    repeat (5376) @(negedge clk);
    #2 sample_valid = 1'b1;
    wait_ready();
    wait_ready();
    wait_slot(6'd40);
    #1 enable = 1'b0;
    @(negedge clk); #1;
    chk_quiet("dis");
    repeat (50) @(negedge clk);
    #2 enable = 1'b1;
    measure_first();
    wait_ready();
    wait_slot(6'd20);
    chk("urun_cnt", underrun_cnt, exp_cnt());
    #1 reset_ = 1'b0;
    #1;
    chk_quiet("arst");
    chk("arst_urun", underrun, 0);
    chk("arst_cnt", underrun_cnt, 0);
    repeat (4) @(negedge clk);
    #2 reset_ = 1'b1;
    measure_first();
    wait_ready();
    #1;
    chk("urun_cnt_end", underrun_cnt, exp_cnt());
    chk("stray_ready", stray_rdy, 0);
    chk("stray_underrun", stray_ur, 0);
    chk("lrck_align", stray_lr, 0);
    chk("sd_align", stray_sd, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
